// File: rtl/eth_pll_reconfig.sv
// Ethernet PLL dynamic-reconfiguration sequencer: MD-port byte writes/reads and relock with timeout.
// Optional lock-loss monitor enabled by defining ETH_PLL_RECONFIG_LOCKMON_EN.
module eth_pll_reconfig #(
    parameter int unsigned RD_LAT       = 2,
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic       mdclk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    input  logic [7:0] mdrdo,
    output logic       pll_reset,
    input  logic       pll_lock
`ifdef ETH_PLL_RECONFIG_LOCKMON_EN
    ,
    output logic       lock_lost,
    output logic [7:0] lock_loss_cnt
`endif
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StWr, StRd, StRdWait, StRstAssert, StLockWait, StResp
    } state_e;

    localparam logic [19:0] RdLast   = 20'(RD_LAT - 1);
    localparam logic [19:0] HoldLast = 20'(RST_HOLD - 1);
    localparam logic [19:0] ToLast   = 20'(LOCK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [19:0] cnt_q, cnt_d;
    logic        lock_meta_q, lock_s_q, lock_prev_q;
    logic        lock_ok;

    logic        cmd_ready_q, rsp_valid_q, rsp_err_q, busy_q, pll_reset_q;
    logic [7:0]  rsp_rdata_q, mdwdi_q;
    logic [1:0]  mdopc_q;
    logic        cmd_ready_d, rsp_valid_d, rsp_err_d, busy_d, pll_reset_d;
    logic [7:0]  rsp_rdata_d, mdwdi_d;
    logic [1:0]  mdopc_d;

    // Synchronised lock must be seen high on two consecutive cycles.
    assign lock_ok = lock_s_q & lock_prev_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rdata_d = 8'h00;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    unique case (cmd_op)
                        2'd0, 2'd1: state_d = StAddr;
                        2'd2:       state_d = StRstAssert;
                        2'd3: begin
                            err_d   = 1'b1;
                            state_d = StResp;
                        end
                    endcase
                end
            end
            StAddr: state_d = (op_q == 2'd0) ? StWr : StRd;
            StWr:   state_d = StResp;
            StRd: begin
                cnt_d   = '0;
                state_d = StRdWait;
            end
            StRdWait: begin
                if (cnt_q == RdLast) begin
                    rdata_d = mdrdo;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            StRstAssert: begin
                if (cnt_q == HoldLast) begin
                    cnt_d   = '0;
                    state_d = StLockWait;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            StLockWait: begin
                if (lock_ok) begin
                    state_d = StResp;
                end else if (cnt_q == ToLast) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        cmd_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        rsp_valid_d = (state_d == StResp);
        rsp_rdata_d = (state_d == StResp) ? rdata_d : 8'h00;
        rsp_err_d   = (state_d == StResp) ? err_d : 1'b0;
        pll_reset_d = (state_d == StRstAssert);
        mdopc_d     = 2'b00;
        mdwdi_d     = 8'h00;
        case (state_d)
            StAddr: begin
                mdopc_d = 2'b11;
                mdwdi_d = addr_d;
            end
            StWr: begin
                mdopc_d = 2'b01;
                mdwdi_d = wdata_d;
            end
            StRd:    mdopc_d = 2'b10;
            default: ;
        endcase
    end

    always_ff @(posedge mdclk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= 2'd0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            lock_prev_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            mdopc_q     <= 2'b00;
            mdwdi_q     <= 8'h00;
            pll_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            lock_prev_q <= lock_s_q;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            mdopc_q     <= mdopc_d;
            mdwdi_q     <= mdwdi_d;
            pll_reset_q <= pll_reset_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign mdopc     = mdopc_q;
    assign mdainc    = 1'b0;
    assign mdwdi     = mdwdi_q;
    assign pll_reset = pll_reset_q;

`ifdef ETH_PLL_RECONFIG_LOCKMON_EN
    logic       armed_q, lock_lost_q;
    logic [7:0] loss_cnt_q;
    logic       relock_ok, lock_fell;

    assign relock_ok = (state_q == StLockWait) && lock_ok;
    // Only count drops once a relock has succeeded, and only while idle.
    assign lock_fell = armed_q && (state_q == StIdle) && lock_prev_q && !lock_s_q;

    always_ff @(posedge mdclk) begin
        if (reset) begin
            armed_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= 8'h00;
        end else if (relock_ok) begin
            armed_q     <= 1'b1;
            lock_lost_q <= 1'b0;
        end else if (lock_fell) begin
            lock_lost_q <= 1'b1;
            if (loss_cnt_q != 8'hFF) begin
                loss_cnt_q <= loss_cnt_q + 8'h01;
            end
        end
    end

    assign lock_lost     = lock_lost_q;
    assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_eth_pll_reconfig.sv
// Scoreboard bench for eth_pll_reconfig with a behavioural PLL MD-port model.
module tb_eth_pll_reconfig;

    localparam int unsigned RD_LAT       = 2;
    localparam int unsigned RST_HOLD     = 16;
    localparam int unsigned LOCK_TIMEOUT = 100;

    logic       mdclk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic [7:0] mdrdo = 8'h00;
    logic       pll_lock = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_err, busy, mdainc, pll_reset;
    logic [7:0] rsp_rdata, mdwdi;
    logic [1:0] mdopc;
`ifdef ETH_PLL_RECONFIG_LOCKMON_EN
    logic       lock_lost;
    logic [7:0] lock_loss_cnt;
`endif

    eth_pll_reconfig #(
        .RD_LAT      (RD_LAT),
        .RST_HOLD    (RST_HOLD),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .mdclk    (mdclk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .mdopc    (mdopc),
        .mdainc   (mdainc),
        .mdwdi    (mdwdi),
        .mdrdo    (mdrdo),
        .pll_reset(pll_reset),
        .pll_lock (pll_lock)
`ifdef ETH_PLL_RECONFIG_LOCKMON_EN
        ,
        .lock_lost    (lock_lost),
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 mdclk = ~mdclk;

    int unsigned cyc = 0;
    always @(posedge mdclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  rdata;
        logic        err;
        int unsigned at;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest pending expectation.
    always @(negedge mdclk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
                check("rsp_cycle", cyc, e.at);
            end
        end
    end

    // PLL MD-port model: address register, 256-byte config space, RD_LAT read pipe.
    logic [7:0]  mem [256];
    logic [7:0]  mdl_addr = 8'h00;
    logic [7:0]  rd_byte = 8'h00;
    int unsigned rd_due = 0;
    always @(negedge mdclk) begin
        mdrdo = (rd_due != 0 && cyc == rd_due) ? rd_byte : 8'h00;
        case (mdopc)
            2'b11: mdl_addr = mdwdi;
            2'b01: mem[mdl_addr] = mdwdi;
            2'b10: begin
                rd_byte = mem[mdl_addr];
                rd_due  = cyc + RD_LAT;
            end
            default: ;
        endcase
    end

    // Caller is at a negedge; expectation is queued before acceptance.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                         input bit push, input logic [7:0] e_rdata, input logic e_err,
                         input int unsigned lat, output int unsigned t0);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge mdclk);
            guard++;
        end
        if (guard >= 50) check("cmd_ready_wait", cmd_ready, 1);
        t0 = cyc;
        if (push) exp_q.push_back('{rdata: e_rdata, err: e_err, at: t0 + lat});
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge mdclk);
        cmd_valid = 1'b0;
    endtask

    task automatic at_k(input int unsigned t0, input int unsigned k);
        while (cyc < t0 + k) @(negedge mdclk);
    endtask

    // Lock rises 10 cycles after pll_reset release (release at k=RST_HOLD+1).
    task automatic relock_ok_seq();
        int unsigned t0;
        pll_lock = 1'b0;
        issue(2'd2, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, RST_HOLD + 15, t0);
        check("relock_mdopc_k1", mdopc, 2'b00);
        check("relock_rst_k1", pll_reset, 1);
        at_k(t0, RST_HOLD);
        check("relock_rst_khold", pll_reset, 1);
        at_k(t0, RST_HOLD + 1);
        check("relock_rst_release", pll_reset, 0);
        at_k(t0, RST_HOLD + 11);
        pll_lock = 1'b1;
        at_k(t0, RST_HOLD + 16);
        check("relock_idle_busy", busy, 0);
    endtask

    int unsigned t0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h05] = 8'h3C;

        repeat (3) @(negedge mdclk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_mdopc", mdopc, 2'b00);
        check("rst_outputs", {busy, rsp_valid, rsp_err, pll_reset, mdainc, rsp_rdata, mdwdi}, 0);
        reset = 1'b0;
        @(negedge mdclk);
        check("post_rst_ready", cmd_ready, 1);

        // Write 0xA5 to 0x1C.
        issue(2'd0, 8'h1C, 8'hA5, 1'b1, 8'h00, 1'b0, 3, t0);
        check("wr_k1_mdopc", mdopc, 2'b11);
        check("wr_k1_mdwdi", mdwdi, 8'h1C);
        check("wr_k1_ready", {busy, cmd_ready}, 2'b10);
        at_k(t0, 2);
        check("wr_k2_mdopc", mdopc, 2'b01);
        check("wr_k2_mdwdi", mdwdi, 8'hA5);
        at_k(t0, 4);
        check("wr_k4_idle", {cmd_ready, mdopc, mdwdi}, {1'b1, 2'b00, 8'h00});

        // Back-to-back read of 0x05.
        issue(2'd1, 8'h05, 8'h00, 1'b1, 8'h3C, 1'b0, 3 + RD_LAT, t0);
        check("rd_k1_mdopc", mdopc, 2'b11);
        at_k(t0, 2);
        check("rd_k2_mdopc", mdopc, 2'b10);
        check("rd_k2_mdwdi", mdwdi, 8'h00);
        at_k(t0, 3);
        check("rd_k3_mdopc", mdopc, 2'b00);
        at_k(t0, 6);

        // Read back the byte written earlier.
        issue(2'd1, 8'h1C, 8'h00, 1'b1, 8'hA5, 1'b0, 3 + RD_LAT, t0);
        at_k(t0, 6);

        // Reserved opcode.
        issue(2'd3, 8'h55, 8'h66, 1'b1, 8'h00, 1'b1, 1, t0);
        check("rsv_k1_md", {mdopc, mdwdi}, 0);
        at_k(t0, 2);

        relock_ok_seq();

`ifdef ETH_PLL_RECONFIG_LOCKMON_EN
        check("lm_lost_init", lock_lost, 0);
        repeat (2) begin
            pll_lock = 1'b0;
            repeat (4) @(negedge mdclk);
            pll_lock = 1'b1;
            repeat (4) @(negedge mdclk);
        end
        check("lm_cnt_two", lock_loss_cnt, 8'd2);
        check("lm_lost_set", lock_lost, 1);
        relock_ok_seq();
        check("lm_lost_clr", lock_lost, 0);
        check("lm_cnt_kept", lock_loss_cnt, 8'd2);
`endif

        // Relock timeout: lock never returns.
        pll_lock = 1'b0;
        issue(2'd2, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, RST_HOLD + LOCK_TIMEOUT + 1, t0);
        at_k(t0, RST_HOLD + LOCK_TIMEOUT);
        check("to_wait_busy", {busy, pll_reset}, 2'b10);
        at_k(t0, RST_HOLD + LOCK_TIMEOUT + 2);
        check("to_after", {busy, pll_reset, cmd_ready}, 3'b001);

        // Reset in the WR cycle of a write: response is dropped.
        issue(2'd0, 8'h2A, 8'h5A, 1'b0, 8'h00, 1'b0, 0, t0);
        at_k(t0, 2);
        check("rstw_k2_mdopc", mdopc, 2'b01);
        reset = 1'b1;
        @(negedge mdclk);
        check("rstw_k3_mdopc", mdopc, 2'b00);
        check("rstw_k3_ready", {cmd_ready, rsp_valid, pll_reset}, 0);
        reset = 1'b0;
        @(negedge mdclk);
        check("rstw_k4_ready", {cmd_ready, busy}, 2'b10);
        repeat (6) @(negedge mdclk);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
